iter_seq_ctrl: RTL and testbench

- Iteration sequencer that sits directly upstream of the registered M==j comparator in the sigmoid/tanh datapath.
- On start it latches an iteration limit M and steps an index j = 0, 1, 2, … while pulsing the iteration datapath once per index.
- It drives the comparator's enable, M and j inputs, consumes the comparator's registered OUT/valid, and terminates with a one-cycle done pulse once j == M has been evaluated.

---
 rtl/iter_seq_ctrl.sv | 104 ++++++++++
 tb/tb_iter_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_seq_ctrl.sv
// Iteration sequencer: latches M, then runs one ISSUE/WAIT round per index j=0..M; done pulse after j==M is confirmed.
// Latency 2(M+1)+1 cycles from accepted start with a 1-cycle comparator; WAIT stalls on missing cmp_valid, abort cancels.
module iter_seq_ctrl #(
    parameter int MW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [MW-1:0] M_in,
    input  logic          cmp_out,
    input  logic          cmp_valid,
    output logic          cmp_en,
    output logic [MW-1:0] cmp_M,
    output logic [MW-1:0] cmp_j,
    output logic          step_en,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [MW-1:0] m_reg;
    logic [MW-1:0] j_reg;
    logic          accept;
    logic          j_inc;
    logic          ovf;

    // abort outranks every transition; in IDLE it is ignored so start still wins
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        j_inc  = 1'b0;
        ovf    = 1'b0;
        if (state != IDLE && abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nxt    = ISSUE;
                        accept = 1'b1;
                    end
                end
                ISSUE: nxt = WAIT;
                WAIT: begin
                    if (cmp_valid) begin
                        if (cmp_out) begin
                            nxt = DONE;
                        end else if (j_reg == {MW{1'b1}}) begin
                            nxt = DONE;
                            ovf = 1'b1;
                        end else begin
                            nxt   = ISSUE;
                            j_inc = 1'b1;
                        end
                    end
                end
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_reg   <= '0;
            j_reg   <= '0;
            cmp_en  <= 1'b0;
            step_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= nxt;
            cmp_en  <= (nxt == ISSUE);
            step_en <= (nxt == ISSUE);
            busy    <= (nxt != IDLE);
            done    <= (nxt == DONE);
            if (accept) begin
                m_reg <= M_in;
                j_reg <= '0;
                err   <= 1'b0;
            end else begin
                if (j_inc) j_reg <= j_reg + 1'b1;
                // a comparator that never matches must not wrap j back to 0
                if (ovf) err <= 1'b1;
            end
        end
    end

    assign cmp_M = m_reg;
    assign cmp_j = j_reg;

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Bench for iter_seq_ctrl: expected timelines come from closed-form cycle arithmetic; comparator is a delayed-valid stub.
module tb_iter_seq_ctrl;
    localparam int MW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [MW-1:0] M_in;
    logic          cmp_out;
    logic          cmp_valid;
    logic          cmp_en;
    logic [MW-1:0] cmp_M;
    logic [MW-1:0] cmp_j;
    logic          step_en;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [1:0] dly;
    logic       force0;
    logic [3:0] vq;
    logic [3:0] oq;

    iter_seq_ctrl #(.MW(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .M_in(M_in),
        .cmp_out(cmp_out), .cmp_valid(cmp_valid), .cmp_en(cmp_en), .cmp_M(cmp_M),
        .cmp_j(cmp_j), .step_en(step_en), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered M==j comparator with 1+dly cycles of latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= '0;
            oq <= '0;
        end else begin
            vq <= {vq[2:0], cmp_en};
            oq <= {oq[2:0], cmp_en && (cmp_M == cmp_j) && !force0};
        end
    end
    assign cmp_valid = vq[dly];
    assign cmp_out   = oq[dly];

    task automatic launch(input int m);
        @(negedge clk);
        M_in  = MW'(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge. Index k counts cycles after that edge.
    task automatic check_seq(input int m, input int d, input bit f0, input bit hold,
                             input int m_next, input string name);
        int k_last = f0 ? (1 << MW) - 1 : m;
        int p      = 2 + d;
        int dc     = 1 + (k_last + 1) * p;
        for (int k = 1; k <= dc; k++) begin
            bit s;
            bit e;
            logic [MW-1:0] ej;
            @(negedge clk);
            s  = ((k - 1) % p == 0) && ((k - 1) / p <= k_last);
            e  = f0 && (k >= dc);
            ej = MW'((k - 1) / p);
            checks++;
            if ({cmp_en, step_en, done, busy, err} !== {s, s, (k == dc), 1'b1, e}) begin
                failures++;
                $display("FAIL %s cyc%0d strobes {en,step,done,busy,err} got %b want %b",
                         name, k, {cmp_en, step_en, done, busy, err}, {s, s, (k == dc), 1'b1, e});
            end
            if (s) begin
                checks++;
                if (cmp_j !== ej || cmp_M !== MW'(m)) begin
                    failures++;
                    $display("FAIL %s cyc%0d j/M got %0d/%0d want %0d/%0d",
                             name, k, cmp_j, cmp_M, ej, m);
                end
            end
            if (hold) begin
                start = 1'b1;
                M_in  = (k == dc) ? MW'(m_next) : MW'($urandom);
            end else begin
                start = 1'b0;
                M_in  = MW'($urandom);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, step_en, done, err} !== {3'b000, f0} || cmp_j !== MW'(k_last)) begin
            failures++;
            $display("FAIL %s idle {busy,step,done,err}=%b j=%0d want %b j=%0d",
                     name, {busy, step_en, done, err}, cmp_j, {3'b000, f0}, k_last);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; M_in = '0; dly = 2'd0; force0 = 1'b0;
        #3;
        checks++;
        if ({cmp_en, step_en, busy, done, err, cmp_M, cmp_j} !== '0) begin
            failures++;
            $display("FAIL reset outputs got %b want 0",
                     {cmp_en, step_en, busy, done, err, cmp_M, cmp_j});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        dly = 2'd0; force0 = 1'b0;
        launch(0);  check_seq(0, 0, 1'b0, 1'b0, 0, "m0");
        launch(5);  check_seq(5, 0, 1'b0, 1'b0, 0, "m5");
        launch(31); check_seq(31, 0, 1'b0, 1'b0, 0, "m31");
        force0 = 1'b1;
        launch(31); check_seq(31, 0, 1'b1, 1'b0, 0, "ovf");
        force0 = 1'b0;
        launch(2);  check_seq(2, 0, 1'b0, 1'b0, 0, "err_clear");
    endtask

    task automatic test_slow_cmp;
        dly = 2'd3;
        launch(2); check_seq(2, 3, 1'b0, 1'b0, 0, "slow3");
        dly = 2'd0;
    endtask

    task automatic test_abort;
        dly = 2'd0;
        launch(4);
        for (int k = 1; k <= 6; k++) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int k = 7; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if ({step_en, done, busy} !== 3'b000 || cmp_j !== MW'(2) || cmp_M !== MW'(4)) begin
                failures++;
                $display("FAIL abort cyc%0d {step,done,busy}=%b j=%0d M=%0d want 000 j=2 M=4",
                         k, {step_en, done, busy}, cmp_j, cmp_M);
            end
        end
        launch(1); check_seq(1, 0, 1'b0, 1'b0, 0, "after_abort");
        // abort in IDLE alongside start: start is still accepted
        @(negedge clk);
        abort = 1'b1; start = 1'b1; M_in = MW'(3);
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0;
        check_seq(3, 0, 1'b0, 1'b0, 0, "idle_abort");
    endtask

    task automatic test_reset_mid;
        dly = 2'd0;
        launch(7);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmp_en, step_en, busy, done, err, cmp_M, cmp_j} !== '0) begin
            failures++;
            $display("FAIL midreset outputs got %b want 0",
                     {cmp_en, step_en, busy, done, err, cmp_M, cmp_j});
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(3); check_seq(3, 0, 1'b0, 1'b0, 0, "post_reset");
    endtask

    task automatic test_start_busy;
        dly = 2'd0;
        launch(6); check_seq(6, 0, 1'b0, 1'b1, 9, "busy_start");
        // start still high in IDLE: next sequence accepted, step_en 2 cycles after done
        @(posedge clk);
        #1;
        start = 1'b0;
        check_seq(9, 0, 1'b0, 1'b0, 0, "back_to_back");
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            int m = $urandom_range(0, 12);
            int d = $urandom_range(0, 3);
            dly = 2'(d);
            launch(m);
            check_seq(m, d, 1'b0, 1'b0, 0, "rand");
        end
        dly = 2'd0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_slow_cmp;
        test_abort;
        test_reset_mid;
        test_start_busy;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
